rctx_sample_logger: RTL and testbench

Trigger-armed capture buffer that sits downstream of the raised-cosine transmit filters in comm_sys. It records the oversampled I/Q filter outputs (one sample per clock, or strobed) into a circular RAM and freezes after a trigger plus a programmable post-trigger count. The frozen window can then be read out with the oldest sample at address 0, for eye-diagram and phase-selection debug of the BER stage.

---
 rtl/rctx_sample_logger.sv | 138 +++++++++++++
 tb/tb_rctx_sample_logger.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rctx_sample_logger.sv
// Trigger-armed circular capture buffer for I/Q filter outputs.
// The buffer freezes after trigger plus post count; readout is relative to the oldest sample.
//
// state | meaning
// IDLE  | no capture since reset, buffer not written
// ARMED | writing every qualified sample, waiting for a qualified trigger
// POST  | writing the post-trigger samples, counting remaining down to zero
// DONE  | buffer frozen, window readable
module rctx_sample_logger #(
  parameter int NB_SAMPLE = 8,
  parameter int NB_ADDR   = 10
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic signed [NB_SAMPLE-1:0] i_sample_i,
  input  logic signed [NB_SAMPLE-1:0] i_sample_q,
  input  logic                        i_valid,
  input  logic                        i_arm,
  input  logic                        i_trigger,
  input  logic        [NB_ADDR-1:0]   i_post_count,
  input  logic        [NB_ADDR-1:0]   i_rd_addr,
  output logic        [2*NB_SAMPLE-1:0] o_rd_data,
  output logic        [1:0]           o_state,
  output logic                        o_done,
  output logic                        o_full,
  output logic        [NB_ADDR-1:0]   o_trig_index
);

  localparam int DEPTH = 1 << NB_ADDR;
  localparam logic [NB_ADDR:0]   DEPTH_C  = (NB_ADDR+1)'(DEPTH);
  localparam logic [NB_ADDR-1:0] DEPTH_M1 = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] ONE_A    = NB_ADDR'(1);
  localparam logic [NB_ADDR:0]   ONE_C    = (NB_ADDR+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_n;
  state_t                 state_q, state_d;
  logic [NB_ADDR-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR:0]       wr_cnt_q, wr_cnt_d;
  logic [NB_ADDR-1:0]     remaining_q, remaining_d;
  logic [NB_ADDR-1:0]     trig_index_q, trig_index_d;
  logic [2*NB_SAMPLE-1:0] rd_data_q, rd_data_d;
  logic [NB_ADDR-1:0]     post;
  logic [NB_ADDR-1:0]     rd_addr_phys;
  logic                   wr_en;

  logic [2*NB_SAMPLE-1:0] mem [DEPTH];

  // Assertion is immediate; release reaches the core two edges later.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // The post count port is NB_ADDR bits wide, so it can never exceed DEPTH-1.
  assign post = i_post_count;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    remaining_d  = remaining_q;
    trig_index_d = trig_index_q;
    wr_en        = 1'b0;
    if (i_arm) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      wr_cnt_d    = '0;
      remaining_d = '0;
    end else begin
      wr_en = ((state_q == ARMED) || (state_q == POST)) && i_valid;
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + ONE_A;
        if (wr_cnt_q != DEPTH_C) wr_cnt_d = wr_cnt_q + ONE_C;
      end
      case (state_q)
        ARMED: begin
          if (wr_en && i_trigger) begin
            remaining_d  = post;
            trig_index_d = DEPTH_M1 - post;
            state_d      = (post == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (wr_en) begin
            remaining_d = remaining_q - ONE_A;
            if (remaining_q == ONE_A) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Relative addressing: wr_ptr points at the oldest entry once the buffer is frozen.
  assign rd_addr_phys = wr_ptr_q + i_rd_addr;
  always_comb rd_data_d = mem[rd_addr_phys];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      remaining_q  <= '0;
      trig_index_q <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      remaining_q  <= remaining_d;
      trig_index_q <= trig_index_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {i_sample_i, i_sample_q};
  end

  assign o_rd_data    = rd_data_q;
  assign o_state      = state_q;
  assign o_done       = (state_q == DONE);
  assign o_full       = (wr_cnt_q == DEPTH_C);
  assign o_trig_index = trig_index_q;

endmodule

// File: tb/tb_rctx_sample_logger.sv
// Directed bench for rctx_sample_logger with DEPTH=16; sample n carries I=n, Q=-n.
module tb_rctx_sample_logger;
  localparam int NB_SAMPLE = 8;
  localparam int NB_ADDR   = 4;

  logic                          clock = 1'b0;
  logic                          i_reset;
  logic signed [NB_SAMPLE-1:0]   i_sample_i, i_sample_q;
  logic                          i_valid, i_arm, i_trigger;
  logic        [NB_ADDR-1:0]     i_post_count, i_rd_addr;
  logic        [2*NB_SAMPLE-1:0] o_rd_data;
  logic        [1:0]             o_state;
  logic                          o_done, o_full;
  logic        [NB_ADDR-1:0]     o_trig_index;

  int tests = 0;
  int fails = 0;
  logic [2*NB_SAMPLE-1:0] exp_q [$];

  rctx_sample_logger #(.NB_SAMPLE(NB_SAMPLE), .NB_ADDR(NB_ADDR)) dut (
    .clock(clock), .i_reset(i_reset),
    .i_sample_i(i_sample_i), .i_sample_q(i_sample_q),
    .i_valid(i_valid), .i_arm(i_arm), .i_trigger(i_trigger),
    .i_post_count(i_post_count), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_state(o_state), .o_done(o_done),
    .o_full(o_full), .o_trig_index(o_trig_index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic trig);
    i_sample_i = 8'(n);
    i_sample_q = 8'(-n);
    i_valid    = v;
    i_trigger  = trig;
    step();
    i_valid    = 1'b0;
    i_trigger  = 1'b0;
  endtask

  task automatic arm();
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int a, input int n);
    i_rd_addr = 4'(a);
    exp_q.push_back({8'(n), 8'(-n)});
    step();
    check(tag, 32'(o_rd_data), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_arm = 1'b0; i_trigger = 1'b0;
    i_sample_i = '0; i_sample_q = '0; i_post_count = '0; i_rd_addr = '0;

    // reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      i_sample_i   = 8'($urandom);
      i_sample_q   = 8'($urandom);
      i_valid      = 1'($urandom);
      i_arm        = 1'($urandom);
      i_trigger    = 1'($urandom);
      i_post_count = 4'($urandom);
      i_rd_addr    = 4'($urandom);
      step();
    end
    check("rst_state", 32'(o_state), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_full", 32'(o_full), 0);
    check("rst_trig", 32'(o_trig_index), 0);
    check("rst_rd", 32'(o_rd_data), 0);
    i_valid = 1'b0; i_arm = 1'b0; i_trigger = 1'b0;
    i_reset = 1'b1;
    repeat (3) step();

    // normal capture: trigger on 20, post 5
    i_post_count = 4'd5;
    arm();
    check("norm_armed", 32'(o_state), 1);
    for (int n = 0; n < 25; n++) drive(n, 1'b1, n == 20);
    check("norm_post_state", 32'(o_state), 2);
    check("norm_not_done", 32'(o_done), 0);
    drive(25, 1'b1, 1'b0);
    check("norm_done", 32'(o_done), 1);
    check("norm_state", 32'(o_state), 3);
    check("norm_full", 32'(o_full), 1);
    check("norm_trig", 32'(o_trig_index), 10);
    for (int a = 0; a < 16; a++) read_chk("norm_rd", a, 10 + a);
    drive(99, 1'b1, 1'b1);
    read_chk("norm_frozen", 15, 25);

    // early trigger: trigger on 3, post 2
    i_post_count = 4'd2;
    arm();
    check("early_armed", 32'(o_state), 1);
    check("early_full_clr", 32'(o_full), 0);
    for (int n = 0; n < 6; n++) drive(n, 1'b1, n == 3);
    check("early_done", 32'(o_done), 1);
    check("early_full", 32'(o_full), 0);
    check("early_trig", 32'(o_trig_index), 13);
    read_chk("early_rd13", 13, 3);
    read_chk("early_rd14", 14, 4);
    read_chk("early_rd15", 15, 5);

    // strobed valid, post 0; triggers on unqualified cycles are ignored
    i_post_count = 4'd0;
    arm();
    drive(50, 1'b0, 1'b1);
    check("strb_ign_trig", 32'(o_state), 1);
    for (int n = 0; n < 2; n++) begin
      drive(n, 1'b1, 1'b0);
      repeat (3) drive(77, 1'b0, 1'b1);
    end
    check("strb_still_armed", 32'(o_state), 1);
    drive(2, 1'b1, 1'b1);
    check("strb_done", 32'(o_state), 3);
    check("strb_trig", 32'(o_trig_index), 15);
    read_chk("strb_rd15", 15, 2);
    read_chk("strb_rd14", 14, 1);
    read_chk("strb_rd13", 13, 0);

    // re-arm during POST
    i_post_count = 4'd5;
    arm();
    for (int n = 0; n < 20; n++) drive(n, 1'b1, n == 18);
    check("rearm_in_post", 32'(o_state), 2);
    check("rearm_full_pre", 32'(o_full), 1);
    i_valid = 1'b1; i_trigger = 1'b1;
    arm();
    i_valid = 1'b0; i_trigger = 1'b0;
    check("rearm_state", 32'(o_state), 1);
    check("rearm_full", 32'(o_full), 0);
    i_post_count = 4'd0;
    drive(40, 1'b1, 1'b1);
    check("rearm_done", 32'(o_state), 3);
    read_chk("rearm_rd15", 15, 40);

    // asynchronous reset during POST
    i_post_count = 4'd5;
    arm();
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b1, 1'b0);
    check("mrst_post", 32'(o_state), 2);
    #2;
    i_reset = 1'b0;
    #1;
    check("mrst_state", 32'(o_state), 0);
    check("mrst_done", 32'(o_done), 0);
    check("mrst_trig", 32'(o_trig_index), 0);
    step();
    i_reset = 1'b1;
    repeat (3) step();
    check("mrst_idle", 32'(o_state), 0);

    // maximum post count
    i_post_count = 4'd15;
    arm();
    for (int n = 0; n < 22; n++) drive(n, 1'b1, n == 7);
    check("sat_not_done", 32'(o_done), 0);
    drive(22, 1'b1, 1'b0);
    check("sat_done", 32'(o_done), 1);
    check("sat_trig", 32'(o_trig_index), 0);
    read_chk("sat_rd0", 0, 7);
    read_chk("sat_rd15", 15, 22);

    // post count 20 presented on a 4-bit port becomes 4
    i_post_count = 4'(20);
    arm();
    for (int n = 0; n < 7; n++) drive(n, 1'b1, n == 3);
    check("trunc_not_done", 32'(o_done), 0);
    drive(7, 1'b1, 1'b0);
    check("trunc_done", 32'(o_done), 1);
    check("trunc_trig", 32'(o_trig_index), 11);
    read_chk("trunc_rd11", 11, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
